// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and helpers for the tick_gen clock-enable generator
//
// Contents:
//   MODE_PERIODIC / MODE_ONESHOT : encodings of the per-channel cfg_mode bit
//   CH_IDX_W(num_ch)             : width of a channel index, never less than 1 bit

package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // A single-channel build still needs a 1-bit select port.
    function automatic int CH_IDX_W(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// rtl/tick_gen_chan.sv - one programmable divider channel of tick_gen
//
// Holds the channel divisor (div_r), mode (mode_r), down-counter and run flag,
// and produces a registered one-cycle tick every div_r+1 cycles (periodic) or
// once (one-shot).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high full clear, div_r <= DEFAULT_DIV
//   sys_reset  in   synchronous stop of the channel; div_r/mode_r kept
//   cfg_we     in   load cfg_div/cfg_mode into div_r/mode_r
//   cfg_div    in   divisor D (period D+1)
//   cfg_mode   in   MODE_PERIODIC or MODE_ONESHOT
//   start      in   start / restart strobe
//   stop       in   stop strobe (wins over start)
//   sync_all   in   reload a running counter from div_r without a tick
//   tick       out  registered one-cycle enable pulse
//   busy       out  channel running

module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int          W           = 25,
    parameter int unsigned DEFAULT_DIV = 27000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sys_reset,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_div,
    input  logic         cfg_mode,
    input  logic         start,
    input  logic         stop,
    input  logic         sync_all,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] DIV_INIT = W'(DEFAULT_DIV);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] div_r;
    logic         mode_r;
    logic [W-1:0] count;
    logic         run;

    // A start in the same cycle as a config write reloads from the value
    // being written, not from the stale register.
    logic [W-1:0] eff_div;

    always_comb begin
        eff_div = div_r;
        if (cfg_we) begin
            eff_div = cfg_div;
        end
    end

    // Configuration registers: only reset and an accepted write change them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r  <= DIV_INIT;
            mode_r <= MODE_PERIODIC;
        end else if (cfg_we && !sys_reset) begin
            div_r  <= cfg_div;
            mode_r <= cfg_mode;
        end
    end

    // Counter / run / tick. Priority: sys_reset > stop > start > sync_all > count.
    // tick defaults low so it can never last longer than one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            run   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sys_reset) begin
                count <= '0;
                run   <= 1'b0;
            end else if (stop) begin
                count <= '0;
                run   <= 1'b0;
            end else if (start) begin
                // Restart drops the current period silently.
                count <= eff_div;
                run   <= 1'b1;
            end else if (run && sync_all) begin
                count <= div_r;
            end else if (run) begin
                if (count == '0) begin
                    tick <= 1'b1;
                    if (mode_r == MODE_ONESHOT) begin
                        run <= 1'b0;
                    end else begin
                        count <= div_r;
                    end
                end else begin
                    count <= count - ONE;
                end
            end
        end
    end

    assign busy = run;

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel runtime-programmable clock-enable generator (top)
//
// NUM_CH independent channels, each with its own W-bit divisor and mode,
// emitting one-cycle tick pulses either periodically (every D+1 cycles) or once.
// Optional feature macro: TICK_GEN_SYNC_EN adds the sync_all input, which
// phase-aligns every running channel by reloading its counter without a tick.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high full clear
//   sys_reset  in   synchronous stop of all channels, config kept
//   cfg_we     in   write cfg_div/cfg_mode into channel cfg_ch
//   cfg_ch     in   channel select for cfg_we
//   cfg_div    in   divisor D, period D+1 cycles
//   cfg_mode   in   0 periodic, 1 one-shot
//   start      in   per-channel start/restart strobe
//   stop       in   per-channel stop strobe
//   sync_all   in   (TICK_GEN_SYNC_EN only) reload all running channels
//   tick       out  per-channel registered one-cycle enable
//   busy       out  per-channel running flag

module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          W           = 25,
    parameter int unsigned DEFAULT_DIV = 27000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sys_reset,
    input  logic                        cfg_we,
    input  logic [CH_IDX_W(NUM_CH)-1:0] cfg_ch,
    input  logic [W-1:0]                cfg_div,
    input  logic                        cfg_mode,
    input  logic [NUM_CH-1:0]           start,
    input  logic [NUM_CH-1:0]           stop,
`ifdef TICK_GEN_SYNC_EN
    input  logic                        sync_all,
`endif
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           busy
);

    localparam int CIW = CH_IDX_W(NUM_CH);

    logic sync_int;

`ifdef TICK_GEN_SYNC_EN
    assign sync_int = sync_all;
`else
    assign sync_int = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CIW-1:0] IDX = CIW'(i);

        // Out-of-range selects (NUM_CH not a power of two) write nothing.
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == IDX);

        tick_gen_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .sys_reset (sys_reset),
            .cfg_we    (ch_we),
            .cfg_div   (cfg_div),
            .cfg_mode  (cfg_mode),
            .start     (start[i]),
            .stop      (stop[i]),
            .sync_all  (sync_int),
            .tick      (tick[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - directed self-checking bench for tick_gen (NUM_CH=4, W=8, DEFAULT_DIV=9)

module tb_tick_gen;

    localparam int NUM_CH      = 4;
    localparam int W           = 8;
    localparam int DEFAULT_DIV = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              sys_reset;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [W-1:0]      cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
`ifdef TICK_GEN_SYNC_EN
    logic              sync_all;
`endif
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tick_gen #(
        .NUM_CH      (NUM_CH),
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sys_reset (sys_reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
`ifdef TICK_GEN_SYNC_EN
        .sync_all  (sync_all),
`endif
        .tick      (tick),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock edge; strobes set before the call are sampled on it and then dropped.
    task automatic step();
        @(posedge clk);
        #1;
        start     = '0;
        stop      = '0;
        cfg_we    = 1'b0;
        sys_reset = 1'b0;
`ifdef TICK_GEN_SYNC_EN
        sync_all  = 1'b0;
`endif
    endtask

    task automatic cfg(input int ch, input int d, input logic m);
        cfg_ch   = ch[1:0];
        cfg_div  = d[W-1:0];
        cfg_mode = m;
        cfg_we   = 1'b1;
    endtask

    // Edges until tick[ch] is seen; -1 if the budget runs out.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < budget);
        if (!tick[ch]) n = -1;
    endtask

    task automatic count_ticks(input int ch, input int cycles, output int c);
        c = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (tick[ch]) c++;
        end
    endtask

    initial begin
        int n;
        int c;
        int t0;
        int t1;

        reset     = 1'b1;
        sys_reset = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_mode  = 1'b0;
        start     = '0;
        stop      = '0;
`ifdef TICK_GEN_SYNC_EN
        sync_all  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Reset state and default divisor
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        start[0] = 1'b1;
        step();
        check("start_busy", 32'(busy[0]), 1);
        check("start_tick", 32'(tick[0]), 0);
        wait_tick(0, 20, n);
        check("default_first_tick", n, 10);
        wait_tick(0, 20, n);
        check("default_period", n, 10);
        step();
        check("tick_one_cycle", 32'(tick[0]), 0);
        stop[0] = 1'b1;
        step();
        check("stop_busy", 32'(busy[0]), 0);

        // One-shot, D=3
        cfg(1, 3, 1'b1);
        step();
        start[1] = 1'b1;
        step();
        wait_tick(1, 10, n);
        check("oneshot_edge", n, 4);
        check("oneshot_busy_fall", 32'(busy[1]), 0);
        count_ticks(1, 12, c);
        check("oneshot_single", c, 0);

        // D=0 periodic: tick held high
        cfg(2, 0, 1'b0);
        step();
        start[2] = 1'b1;
        step();
        count_ticks(2, 8, c);
        check("d0_continuous", c, 8);
        stop[2] = 1'b1;
        step();
        check("d0_stop_no_tick", 32'(tick[2]), 0);

        // Config and start in the same cycle, then rewrite while running
        cfg(0, 5, 1'b0);
        start[0] = 1'b1;
        step();
        wait_tick(0, 20, n);
        check("cfg_start_period", n, 6);
        cfg(0, 2, 1'b0);
        step();
        wait_tick(0, 20, n);
        check("rewrite_current_kept", n, 5);
        wait_tick(0, 20, n);
        check("rewrite_new_period", n, 3);

        // Restart at count=2
        start[0] = 1'b1;
        step();
        check("restart_no_tick", 32'(tick[0]), 0);
        wait_tick(0, 20, n);
        check("restart_period", n, 3);

        // start+stop together: stop wins
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        step();
        check("start_stop_busy", 32'(busy[3]), 0);
        count_ticks(3, 12, c);
        check("start_stop_no_tick", c, 0);

        // sys_reset mid-period, overriding start and cfg_we
        cfg(1, 6, 1'b0);
        step();
        start[1] = 1'b1;
        step();
        repeat (3) step();
        sys_reset = 1'b1;
        start[3]  = 1'b1;
        cfg(2, 1, 1'b0);
        step();
        check("sysrst_busy", 32'(busy), 0);
        check("sysrst_tick", 32'(tick), 0);
        start[1] = 1'b1;
        step();
        wait_tick(1, 20, n);
        check("sysrst_div_kept", n, 7);
        stop[1]  = 1'b1;
        start[2] = 1'b1;
        step();
        wait_tick(2, 5, n);
        check("sysrst_cfg_ignored", n, 1);
        stop[2] = 1'b1;
        step();

        // Asynchronous reset between edges
        start[1] = 1'b1;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_tick", 32'(tick), 0);
        #2 reset = 1'b0;
        start[1] = 1'b1;
        step();
        wait_tick(1, 20, n);
        check("async_default_div", n, 10);
        stop[1] = 1'b1;
        step();

`ifdef TICK_GEN_SYNC_EN
        // Phase alignment
        cfg(0, 4, 1'b0);
        step();
        cfg(1, 7, 1'b0);
        step();
        start[0] = 1'b1;
        step();
        step();
        step();
        start[1] = 1'b1;
        step();
        sync_all = 1'b1;
        step();
        check("sync_no_tick", 32'(tick), 0);
        t0 = -1;
        t1 = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick[0] && t0 < 0) t0 = k;
            if (tick[1] && t1 < 0) t1 = k;
        end
        check("sync_ch0", t0, 5);
        check("sync_ch1", t1, 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
